// File: rtl/piano_pkg.sv
// Shared constants for the piano renderer: colours, scan-decoder states,
// the PS/2 scan-code to key table and the semitone layout of an octave.
package piano_pkg;

    localparam logic [2:0] COLOR_BLACK  = 3'b000;
    localparam logic [2:0] COLOR_BLUE   = 3'b001;
    localparam logic [2:0] COLOR_YELLOW = 3'b110;
    localparam logic [2:0] COLOR_WHITE  = 3'b111;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} scan_state_t;

    // Entry i is the make code of key i (octave*12 + semitone).
    localparam logic [0:23][7:0] SCAN_TABLE = {
        8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
        8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C
    };

    // Returns {hit, key}.
    function automatic logic [5:0] scan_lookup(input logic [7:0] code);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 24; i++)
            if (SCAN_TABLE[i] == code) r = {1'b1, 5'(i)};
        return r;
    endfunction

    function automatic logic [3:0] white_semi(input logic [2:0] wk);
        case (wk)
            3'd0: return 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd4;
            3'd3: return 4'd5;
            3'd4: return 4'd7;
            3'd5: return 4'd9;
            default: return 4'd11;
        endcase
    endfunction

    // Semitone of the black key sitting to the right of white key wk.
    function automatic logic [3:0] black_semi(input logic [2:0] wk);
        case (wk)
            3'd0: return 4'd1;
            3'd1: return 4'd3;
            3'd3: return 4'd6;
            3'd4: return 4'd8;
            3'd5: return 4'd10;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/piano_key_tracker.sv
// PS/2 make/break decoder plus per-key held bit and post-release sustain
// counter; exports a registered lit mask.
module piano_key_tracker
    import piano_pkg::*;
#(
    parameter int OCTAVES        = 1,
    parameter int SUSTAIN_FRAMES = 8
) (
    input  logic                   gclk,
    input  logic                   grst_n,
    input  logic [7:0]             scan_code,
    input  logic                   scan_valid,
    input  logic                   frame_tick,
    output logic [12*OCTAVES-1:0]  key_mask
);
    localparam int NK = 12 * OCTAVES;
    localparam int CW = (SUSTAIN_FRAMES > 0) ? $clog2(SUSTAIN_FRAMES + 1) : 1;

    scan_state_t state, state_nxt;
    logic        hit, key_ok, make_ev, brk_ev;
    logic [4:0]  key;

    logic [NK-1:0]         held, held_nxt, mask_nxt;
    logic [NK-1:0][CW-1:0] cnt, cnt_nxt;

    assign {hit, key} = scan_lookup(scan_code);
    assign key_ok     = hit && (key < 5'(NK));

    always_comb begin
        state_nxt = state;
        make_ev   = 1'b0;
        brk_ev    = 1'b0;
        if (scan_valid) begin
            case (state)
                S_IDLE: begin
                    if (scan_code == CODE_BREAK)    state_nxt = S_BREAK;
                    else if (scan_code == CODE_EXT) state_nxt = S_EXT;
                    else                            make_ev   = key_ok;
                end
                S_BREAK: begin
                    brk_ev    = key_ok;
                    state_nxt = S_IDLE;
                end
                S_EXT:   state_nxt = (scan_code == CODE_BREAK) ? S_EXT_BREAK : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A make/break on a key takes priority over that key's frame decrement.
    always_comb begin
        held_nxt = held;
        cnt_nxt  = cnt;
        mask_nxt = '0;
        for (int k = 0; k < NK; k++) begin
            if (make_ev && key == 5'(k)) begin
                held_nxt[k] = 1'b1;
                cnt_nxt[k]  = CW'(SUSTAIN_FRAMES);
            end else if (brk_ev && key == 5'(k)) begin
                held_nxt[k] = 1'b0;
            end else if (frame_tick && !held[k] && cnt[k] != '0) begin
                cnt_nxt[k] = cnt[k] - CW'(1);
            end
            mask_nxt[k] = held_nxt[k] | (cnt_nxt[k] != '0);
        end
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            state    <= S_IDLE;
            held     <= '0;
            cnt      <= '0;
            key_mask <= '0;
        end else begin
            state    <= state_nxt;
            held     <= held_nxt;
            cnt      <= cnt_nxt;
            key_mask <= mask_nxt;
        end
    end

endmodule

// File: rtl/piano_key_renderer.sv
// Multi-octave piano keyboard renderer: two-stage pixel pipeline driven by
// crvga's column/row, colouring lit keys from the key tracker's mask.
module piano_key_renderer
    import piano_pkg::*;
#(
    parameter int OCTAVES        = 1,
    parameter int X0             = 0,
    parameter int WHITE_W        = 53,
    parameter int LINE_W         = 4,
    parameter int BLACK_W        = 32,
    parameter int Y_TOP          = 100,
    parameter int Y_BOT          = 380,
    parameter int Y_BLACK        = 240,
    parameter int SUSTAIN_FRAMES = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [7:0]            iScanCode,
    input  logic                  iScanValid,
    input  logic [31:0]           iCurrentCol,
    input  logic [31:0]           iCurrentRow,
    output logic                  oVGA_R,
    output logic                  oVGA_G,
    output logic                  oVGA_B,
    output logic [12*OCTAVES-1:0] oKeyMask
);
    localparam int XW = $clog2(WHITE_W);
    localparam int OW = $clog2(OCTAVES + 1);

    localparam logic [31:0] COL_LO  = 32'(X0);
    localparam logic [31:0] COL_HI  = 32'(X0 + 7 * OCTAVES * WHITE_W);
    localparam logic [31:0] ROW_LO  = 32'(Y_TOP);
    localparam logic [31:0] ROW_HI  = 32'(Y_BOT);
    localparam logic [31:0] ROW_BLK = 32'(Y_BLACK);

    localparam logic [XW-1:0] X_LAST   = XW'(WHITE_W - 1);
    localparam logic [XW-1:0] X_SEP    = XW'(WHITE_W - LINE_W);
    localparam logic [XW-1:0] X_BRIGHT = XW'(WHITE_W - BLACK_W / 2);
    localparam logic [XW-1:0] X_BLEFT  = XW'(BLACK_W / 2);

    logic frame_tick;
    assign frame_tick = (iCurrentCol == 32'd0) && (iCurrentRow == 32'd0);

    piano_key_tracker #(.OCTAVES(OCTAVES), .SUSTAIN_FRAMES(SUSTAIN_FRAMES)) u_tracker (
        .gclk       (Clock),
        .grst_n     (Reset),
        .scan_code  (iScanCode),
        .scan_valid (iScanValid),
        .frame_tick (frame_tick),
        .key_mask   (oKeyMask)
    );

    // Stage 1: running position within the keyboard; sync holds the output
    // black after reset until the counters have seen a line start.
    logic [XW-1:0] x_r;
    logic [2:0]    wk_r;
    logic [OW-1:0] oct_r;
    logic          in_kbd_r, upper_r, sync_r;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            x_r      <= '0;
            wk_r     <= '0;
            oct_r    <= '0;
            in_kbd_r <= 1'b0;
            upper_r  <= 1'b0;
            sync_r   <= 1'b0;
        end else begin
            if (iCurrentCol == COL_LO) begin
                x_r    <= '0;
                wk_r   <= '0;
                oct_r  <= '0;
                sync_r <= 1'b1;
            end else if (x_r == X_LAST) begin
                x_r <= '0;
                if (wk_r == 3'd6) begin
                    wk_r  <= '0;
                    oct_r <= oct_r + OW'(1);
                end else begin
                    wk_r <= wk_r + 3'd1;
                end
            end else begin
                x_r <= x_r + XW'(1);
            end
            in_kbd_r <= (iCurrentCol >= COL_LO) && (iCurrentCol < COL_HI) &&
                        (iCurrentRow >= ROW_LO) && (iCurrentRow < ROW_HI);
            upper_r  <= iCurrentRow < ROW_BLK;
        end
    end

    // Stage 2: colour.  Padding the mask to 64 bits makes any out-of-range
    // key index (free-running oct beyond the keyboard) read as unlit.
    logic [63:0] mask_ext;
    logic [5:0]  oct_base, black_idx, white_idx;
    logic        blk_right, blk_left;
    logic [2:0]  color_nxt, color_r;

    assign mask_ext = 64'(oKeyMask);

    always_comb begin
        blk_right = upper_r && (x_r >= X_BRIGHT) && (wk_r inside {3'd0, 3'd1, 3'd3, 3'd4, 3'd5});
        blk_left  = upper_r && (x_r <  X_BLEFT)  && (wk_r inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6});
        oct_base  = 6'(oct_r) * 6'd12;
        black_idx = oct_base + 6'(black_semi(blk_right ? wk_r : wk_r - 3'd1));
        white_idx = oct_base + 6'(white_semi(wk_r));
        color_nxt = COLOR_BLACK;
        if (!sync_r)                  color_nxt = COLOR_BLACK;
        else if (!in_kbd_r)           color_nxt = COLOR_BLUE;
        else if (blk_right || blk_left)
            color_nxt = mask_ext[black_idx] ? COLOR_YELLOW : COLOR_BLACK;
        else if (x_r >= X_SEP)        color_nxt = COLOR_BLACK;
        else
            color_nxt = mask_ext[white_idx] ? COLOR_YELLOW : COLOR_WHITE;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) color_r <= COLOR_BLACK;
        else        color_r <= color_nxt;
    end

    assign {oVGA_R, oVGA_G, oVGA_B} = color_r;

endmodule
